video_dram_arb: RTL and testbench

VIDEO_DRAM_ARB -- requirements
Module: video_dram_arb

---
 rtl/video_dram_arb.sv | 131 +++++++++++++
 tb/tb_video_dram_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_dram_arb.sv
// Video DRAM slot arbiter: each slot_stb grants one access, to the video fetch first
// and then to the CPU, with DMA and the tile/sprite renderer sharing the rest round-robin.
module video_dram_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        slot_stb,
   input  logic        line_start,
   input  logic [4:0]  video_bw,
   input  logic        vid_act,
   input  logic [20:0] vid_addr,
   input  logic        cpu_req,
   input  logic [20:0] cpu_addr,
   input  logic        dma_req,
   input  logic [20:0] dma_addr,
   input  logic        tsr_req,
   input  logic [20:0] tsr_addr,
   output logic        gnt_vid,
   output logic        gnt_cpu,
   output logic        gnt_dma,
   output logic        gnt_tsr,
   output logic [20:0] dram_addr,
   output logic [2:0]  slot_pos,
   output logic [8:0]  vid_cnt,
   output logic        vid_short
);

   localparam logic [4:0] BW_RESET = 5'b11001;
   localparam logic [8:0] CNT_MAX  = 9'd511;

   function automatic logic [3:0] dec_len(input logic [1:0] sel);
      case (sel)
         2'b00:   return 4'd2;
         2'b01:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [3:0] dec_need(input logic [4:0] bw);
      logic [3:0] n;
      case (bw[2:0])
         3'b010:  n = 4'd2;
         3'b100:  n = 4'd4;
         default: n = 4'd1;
      endcase
      if (n > dec_len(bw[4:3])) n = dec_len(bw[4:3]);
      return n;
   endfunction

   logic [4:0]  bw_reg;
   logic [4:0]  bw_cur;
   logic [3:0]  len_cur;
   logic [3:0]  need_cur;
   logic [3:0]  need_old;
   logic [2:0]  arb_pos;
   logic [2:0]  next_pos;
   logic        rr_tsr;      // 1: TSR was granted less recently than DMA
   logic        pick_vid, pick_cpu, pick_dma, pick_tsr;
   logic [20:0] pick_addr;

   // A line_start arriving with a slot_stb re-times the window immediately.
   assign bw_cur   = line_start ? video_bw : bw_reg;
   assign arb_pos  = line_start ? 3'd0 : slot_pos;
   assign len_cur  = dec_len(bw_cur[4:3]);
   assign need_cur = dec_need(bw_cur);
   assign need_old = dec_need(bw_reg);
   assign next_pos = ({1'b0, arb_pos} >= len_cur - 4'd1) ? 3'd0 : arb_pos + 3'd1;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      pick_vid  = 1'b0;
      pick_cpu  = 1'b0;
      pick_dma  = 1'b0;
      pick_tsr  = 1'b0;
      pick_addr = dram_addr;
      if (vid_act && ({1'b0, arb_pos} < need_cur)) begin
         pick_vid  = 1'b1;
         pick_addr = vid_addr;
      end else if (cpu_req) begin
         pick_cpu  = 1'b1;
         pick_addr = cpu_addr;
      end else if (dma_req && (!tsr_req || !rr_tsr)) begin
         pick_dma  = 1'b1;
         pick_addr = dma_addr;
      end else if (tsr_req) begin
         pick_tsr  = 1'b1;
         pick_addr = tsr_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bw_reg    <= BW_RESET;
         slot_pos  <= 3'd0;
         gnt_vid   <= 1'b0;
         gnt_cpu   <= 1'b0;
         gnt_dma   <= 1'b0;
         gnt_tsr   <= 1'b0;
         dram_addr <= 21'd0;
         vid_cnt   <= 9'd0;
         vid_short <= 1'b0;
         rr_tsr    <= 1'b0;
      end else begin
         gnt_vid <= slot_stb && pick_vid;
         gnt_cpu <= slot_stb && pick_cpu;
         gnt_dma <= slot_stb && pick_dma;
         gnt_tsr <= slot_stb && pick_tsr;

         if (line_start) bw_reg <= video_bw;

         // Window cut short while the current window still owed video slots.
         if (line_start && vid_act && slot_pos != 3'd0 && ({1'b0, slot_pos} < need_old))
            vid_short <= 1'b1;

         if (slot_stb) begin
            slot_pos  <= next_pos;
            dram_addr <= pick_addr;
            if (pick_dma) rr_tsr <= 1'b1;
            else if (pick_tsr) rr_tsr <= 1'b0;
         end else if (line_start) begin
            slot_pos <= 3'd0;
         end

         if (line_start)
            vid_cnt <= (slot_stb && pick_vid) ? 9'd1 : 9'd0;
         else if (slot_stb && pick_vid && vid_cnt != CNT_MAX)
            vid_cnt <= vid_cnt + 9'd1;
      end
   end

endmodule

// File: tb/tb_video_dram_arb.sv
// Bench for video_dram_arb: directed scenarios followed by random traffic, all
// checked each clock against a slot-level reference model.
module tb_video_dram_arb;

   logic        clk = 1'b0;
   logic        rst, slot_stb, line_start, vid_act, cpu_req, dma_req, tsr_req;
   logic [4:0]  video_bw;
   logic [20:0] vid_addr, cpu_addr, dma_addr, tsr_addr;
   logic        gnt_vid, gnt_cpu, gnt_dma, gnt_tsr, vid_short;
   logic [20:0] dram_addr;
   logic [2:0]  slot_pos;
   logic [8:0]  vid_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          t = 0;
   logic [4:0]  m_bw;
   int          m_pos, m_cnt, last_dma_t, last_tsr_t;
   logic        m_short;
   logic [20:0] m_addr;
   logic [3:0]  m_gnt;          // {vid, cpu, dma, tsr}
   logic [20:0] last_vid_addr;

   always #5 clk = ~clk;

   video_dram_arb dut (
      .clk(clk), .rst(rst), .slot_stb(slot_stb), .line_start(line_start),
      .video_bw(video_bw), .vid_act(vid_act), .vid_addr(vid_addr),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .dma_req(dma_req), .dma_addr(dma_addr),
      .tsr_req(tsr_req), .tsr_addr(tsr_addr),
      .gnt_vid(gnt_vid), .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma), .gnt_tsr(gnt_tsr),
      .dram_addr(dram_addr), .slot_pos(slot_pos), .vid_cnt(vid_cnt), .vid_short(vid_short)
   );

   function automatic int win_len(input logic [4:0] bw);
      if (bw[4:3] == 2'b00) return 2;
      if (bw[4:3] == 2'b01) return 4;
      return 8;
   endfunction

   function automatic int vid_need(input logic [4:0] bw);
      int n;
      n = (bw[2:0] == 3'b010) ? 2 : (bw[2:0] == 3'b100) ? 4 : 1;
      return (n < win_len(bw)) ? n : win_len(bw);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      m_bw       = 5'b11001;
      m_pos      = 0;
      m_cnt      = 0;
      m_short    = 1'b0;
      m_addr     = '0;
      m_gnt      = '0;
      last_dma_t = -2;           // DMA preferred out of reset
      last_tsr_t = -1;
   endtask

   // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
   task automatic cyc(input bit r, input bit stb, input bit ls, input logic [4:0] bw,
                      input bit va, input bit cr, input bit dr, input bit tr);
      int L, N;
      rst = r; slot_stb = stb; line_start = ls; video_bw = bw;
      vid_act = va; cpu_req = cr; dma_req = dr; tsr_req = tr;
      vid_addr = 21'($urandom); cpu_addr = 21'($urandom);
      dma_addr = 21'($urandom); tsr_addr = 21'($urandom);
      t++;
      if (r) begin
         model_reset();
      end else begin
         m_gnt = '0;
         if (ls) begin
            if (va && m_pos >= 1 && m_pos < vid_need(m_bw)) m_short = 1'b1;
            m_bw  = bw;
            m_pos = 0;
            m_cnt = 0;
         end
         if (stb) begin
            L = win_len(m_bw);
            N = vid_need(m_bw);
            if (va && m_pos < N) begin
               m_gnt = 4'b1000; m_addr = vid_addr;
               if (m_cnt < 511) m_cnt++;
            end else if (cr) begin
               m_gnt = 4'b0100; m_addr = cpu_addr;
            end else if (dr && (!tr || last_dma_t < last_tsr_t)) begin
               m_gnt = 4'b0010; m_addr = dma_addr; last_dma_t = t;
            end else if (tr) begin
               m_gnt = 4'b0001; m_addr = tsr_addr; last_tsr_t = t;
            end
            m_pos = (m_pos + 1) % L;
         end
      end
      if (va) last_vid_addr = vid_addr;
      @(posedge clk);
      #1;
      check("gnt",       {28'd0, gnt_vid, gnt_cpu, gnt_dma, gnt_tsr}, {28'd0, m_gnt});
      check("dram_addr", {11'd0, dram_addr}, {11'd0, m_addr});
      check("slot_pos",  {29'd0, slot_pos}, 32'(m_pos));
      check("vid_cnt",   {23'd0, vid_cnt}, 32'(m_cnt));
      check("vid_short", {31'd0, vid_short}, {31'd0, m_short});
   endtask

   task automatic idle();
      cyc(0, 0, 0, 5'd0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [20:0] held;
      model_reset();
      last_vid_addr = '0;

      // Reset state
      cyc(1, 0, 0, 5'd0, 0, 0, 0, 0);
      cyc(1, 1, 1, 5'b01010, 1, 1, 1, 1);
      check("rst_pos", {29'd0, slot_pos}, 32'd0);
      check("rst_gnt", {28'd0, gnt_vid, gnt_cpu, gnt_dma, gnt_tsr}, 32'd0);

      // 8/4 video with CPU contending for the remaining slots
      cyc(0, 0, 1, 5'b11100, 1, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, 0, 5'd0, 1, 1, 0, 0);
         check("r035_vid", {31'd0, gnt_vid}, {31'd0, ((i % 8) < 4)});
         check("r035_cpu", {31'd0, gnt_cpu}, {31'd0, ((i % 8) >= 4)});
      end
      check("r035_cnt", {23'd0, vid_cnt}, 32'd8);

      // DMA/TSR alternate from reset
      cyc(1, 0, 0, 5'd0, 0, 0, 0, 0);
      cyc(0, 0, 1, 5'b00001, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 5'd0, 0, 0, 1, 1);
         check("r036_rr", {30'd0, gnt_dma, gnt_tsr}, (i % 2 == 0) ? 32'd2 : 32'd1);
         idle();
      end

      // 4/2 video, idle slots keep the last video address
      cyc(0, 0, 1, 5'b01010, 1, 0, 0, 0);
      cyc(0, 1, 0, 5'd0, 1, 0, 0, 0);
      cyc(0, 1, 0, 5'd0, 1, 0, 0, 0);
      held = last_vid_addr;
      check("r037_vid_addr", {11'd0, dram_addr}, {11'd0, held});
      for (int i = 0; i < 2; i++) begin
         cyc(0, 1, 0, 5'd0, 1, 0, 0, 0);
         check("r037_nogrant", {28'd0, gnt_vid, gnt_cpu, gnt_dma, gnt_tsr}, 32'd0);
         check("r037_hold", {11'd0, dram_addr}, {11'd0, held});
      end

      // Window cut short at slot 1 of an 8/4 window
      cyc(1, 0, 0, 5'd0, 0, 0, 0, 0);
      cyc(0, 0, 1, 5'b11100, 1, 0, 0, 0);
      cyc(0, 1, 0, 5'd0, 1, 0, 0, 0);
      cyc(0, 0, 1, 5'b11100, 1, 0, 0, 0);
      check("r038_short", {31'd0, vid_short}, 32'd1);
      check("r038_pos",   {29'd0, slot_pos}, 32'd0);
      check("r038_cnt",   {23'd0, vid_cnt}, 32'd0);

      // line_start together with slot_stb, new window of length 4
      cyc(0, 1, 1, 5'b01001, 1, 1, 0, 0);
      check("r039_vid", {31'd0, gnt_vid}, 32'd1);
      check("r039_pos", {29'd0, slot_pos}, 32'd1);
      check("r039_cnt", {23'd0, vid_cnt}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 5'd0, 0, 0, 0, 0);
      check("r039_wrap", {29'd0, slot_pos}, 32'd0);
      check("r039_short_sticky", {31'd0, vid_short}, 32'd1);

      // Reset overrides a slot_stb in the same clock
      cyc(0, 1, 0, 5'd0, 0, 1, 0, 0);
      cyc(1, 1, 0, 5'd0, 0, 1, 0, 0);
      check("r040_gnt",   {28'd0, gnt_vid, gnt_cpu, gnt_dma, gnt_tsr}, 32'd0);
      check("r040_addr",  {11'd0, dram_addr}, 32'd0);
      check("r040_cnt",   {23'd0, vid_cnt}, 32'd0);
      check("r040_short", {31'd0, vid_short}, 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 19) == 0), 5'($urandom),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
